// File: rtl/axil_pkg.sv
// Shared types and constants for the command-to-AXI4-Lite master bridge.
// The optional watchdog build is selected with the AXIL_TIMEOUT_EN macro.
package axil_pkg;

    localparam int AXIL_ADDR_W      = 16;
    localparam int AXIL_DATA_W      = 32;
    localparam int AXIL_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } axil_state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    function automatic logic is_wait_state(input axil_state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
               (s == ST_RD_REQ) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Per-channel wait watchdog: counts cycles while active, flags the cycle in
// which the count reaches LIMIT so the master can abandon the wait next cycle.
module axil_watchdog #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !active) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // count holds cycles already spent, so LAST means this is cycle LIMIT
    assign tc = active && (count == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding command port to AXI4-Lite master bridge.
// Define AXIL_TIMEOUT_EN to build the channel-wait watchdog (rsp_resp = 11 on expiry).
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_REQ  | AW and W valid, each dropped after its own handshake
// ST_WR_RESP | bready high, waiting for the write response
// ST_RD_REQ  | arvalid high, waiting for arready
// ST_RD_DATA | rready high, waiting for read data
// ST_RSP     | rsp_valid high, fields held until rsp_ready
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_W         = AXIL_ADDR_W,
    parameter int DATA_W         = AXIL_DATA_W,
    parameter int TIMEOUT_CYCLES = AXIL_TIMEOUT_DEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

    axil_state_t       state, state_next;
    logic              aw_done, w_done;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              aw_hs, w_hs, ar_hs;
    logic              timeout_fire;

    assign aw_hs = (state == ST_WR_REQ) && !aw_done && m_axi_awready;
    assign w_hs  = (state == ST_WR_REQ) && !w_done && m_axi_wready;
    assign ar_hs = (state == ST_RD_REQ) && m_axi_arready;

`ifdef AXIL_TIMEOUT_EN
    logic wd_tc;

    axil_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (aclk),
        .rst    (areset),
        .clear  ((state_next != state) || aw_hs || w_hs || ar_hs),
        .active (is_wait_state(state)),
        .tc     (wd_tc)
    );
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        timeout_fire  = 1'b0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            ST_IDLE: begin
                // areset gating keeps cmd_ready low for the whole reset pulse
                cmd_ready = !areset;
                if (cmd_valid && !areset) begin
                    state_next = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = ST_RSP;
            end
            ST_RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_next = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef AXIL_TIMEOUT_EN
        // forward progress this cycle beats an expiring watchdog
        if (wd_tc && (state_next == state)) begin
            state_next   = ST_RSP;
            timeout_fire = 1'b1;
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            if (state == ST_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (cmd_valid) begin
                    write_q <= cmd_write;
                    addr_q  <= cmd_addr;
                    wdata_q <= cmd_wdata;
                end
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if ((state == ST_WR_RESP) && m_axi_bvalid) begin
                resp_q  <= m_axi_bresp;
                rdata_q <= '0;
            end
            if ((state == ST_RD_DATA) && m_axi_rvalid) begin
                resp_q  <= m_axi_rresp;
                rdata_q <= m_axi_rdata;
            end
            if (timeout_fire) begin
                resp_q  <= RESP_TIMEOUT;
                rdata_q <= '0;
            end
        end
    end

    assign rsp_write    = write_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Command-to-AXI4-Lite master bridge that drives the 16-bit-address, 32-bit-data BRAM slave (`axi_bram`) from a simple single-beat command port. It accepts one read or write command, runs the matching AXI4-Lite handshakes, and returns a single response beat carrying read data and the slave's response code. It sits directly upstream of the BRAM slave and replaces hand-driven channel stimulus in system builds.

## Interface
- `ADDR_W`, 16, address width; matches the BRAM slave.
- `DATA_W`, 32, data width.
- `TIMEOUT_CYCLES`, 64, watchdog limit per channel wait. Used only with `AXIL_TIMEOUT_EN`.

Ports:
- `aclk` in 1: clock; all logic on the rising edge.
- `areset` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_write` out 1: echo of `cmd_write`.
- `rsp_rdata` out DATA_W: read data; 0 for writes.
- `rsp_resp` out 2: AXI response code (OKAY 00, SLVERR 10, timeout 11).
- `m_axi_awvalid`/`m_axi_awready`/`m_axi_awaddr`: out/in/out, widths 1/1/ADDR_W.
- `m_axi_wvalid`/`m_axi_wready`/`m_axi_wdata`: out/in/out, widths 1/1/DATA_W.
- `m_axi_bvalid`/`m_axi_bready`/`m_axi_bresp`: in/out/in, widths 1/1/2.
- `m_axi_arvalid`/`m_axi_arready`/`m_axi_araddr`: out/in/out, widths 1/1/ADDR_W.
- `m_axi_rvalid`/`m_axi_rready`/`m_axi_rdata`/`m_axi_rresp`: in/out/in/in, widths 1/1/DATA_W/2.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, register addr, data and write flag.
  - Write: go to WR_REQ.
  - Read: go to RD_REQ.
- WR_REQ: `awvalid` and `wvalid` are both raised together. Each is held, with stable addr/data, until its own handshake.
  - The two handshakes complete independently, in either order or in the same cycle. Per-channel "done" flags track them.
  - When both are done, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp`, set `rsp_rdata`=0, go to RSP.
- RD_REQ: `arvalid` is held until `arready`, then go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture `rdata` and `rresp`, go to RSP.
- RSP: `rsp_valid`=1 with fields stable until `rsp_ready`, then go to IDLE.
- Only one transaction is outstanding at a time. `cmd_ready`=0 in every state except IDLE.
- Reset mid-transaction: the FSM goes to IDLE at once and all valids drop. The in-flight command is discarded and no response is produced.

## Timing
- Reset values:
  - `cmd_ready`=0 while `areset` is high, and 1 in the first cycle after release.
  - All `m_axi_*valid`/`*ready` outputs are 0; `rsp_valid`=0.
  - `rsp_rdata`=0, `rsp_resp`=00, `rsp_write`=0; addr/data outputs are 0.
- Cycle numbering below: accept at cycle N, with a zero-wait slave.
  - Write: AW/W valid in N+1, `bready` in N+2, `rsp_valid` in N+3.
  - Read: `arvalid` in N+1, `rready` in N+2, `rsp_valid` in N+3.
  - If `rsp_ready` is high in N+3, the next command is accepted in N+4.
- Slave wait states add cycles one-for-one. Valids never drop before their handshake (no timeout build).
- `bvalid`/`rvalid` asserted outside WR_RESP/RD_DATA are ignored.

## Configuration
- Macro: `AXIL_TIMEOUT_EN`.
- Defined:
  - A watchdog counter clears on entry to WR_REQ, WR_RESP, RD_REQ and RD_DATA, and on each channel handshake.
  - It increments every other cycle spent in those states.
  - When it reaches `TIMEOUT_CYCLES`, all valids/readies drop the next cycle and the FSM enters RSP with `rsp_resp`=11 and `rsp_rdata`=0.
- Undefined: no counter is built. The block waits indefinitely and `rsp_resp` only ever carries the slave's code.

## Structure
- Shared package `axil_pkg`: the FSM state enum, response codes (OKAY, SLVERR, TIMEOUT = 2'b11), and default widths.
- One sub-module, `axil_watchdog`: the counter plus a terminal-count flag, instantiated only under `AXIL_TIMEOUT_EN`.

## Test plan
- Write 0x0000000A to 0x0001 with a zero-wait slave -> `awvalid`/`wvalid` in accept+1, `rsp_valid` in accept+3, `rsp_resp`=00, `rsp_rdata`=0.
- Write 0x110A0FB9 to 0xAA0F, with `wready` one cycle before `awready` -> `wvalid` drops first, `awvalid` is held. Then read 0xAA0F -> `rsp_rdata`=0x110A0FB9, `rsp_write`=0.
- Read with `rvalid` delayed 10 cycles and `rsp_ready` low 3 cycles -> `rready` held 10 cycles, response fields stable across the stall, `cmd_ready` low until `rsp_ready`.
- `areset` pulsed while in WR_RESP -> all valids 0 asynchronously, `rsp_valid` never asserted, IDLE with `cmd_ready`=1 after release.
- `AXIL_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8 and `arready` tied low -> `arvalid` drops after 8 cycles, `rsp_resp`=11; a following write completes normally with 00.
